// File: rtl/ram_sp_sr_sw_be.sv
// ---------------------------------------------------------------------------
// ram_sp_sr_sw_be
//   Parametrised single-port synchronous RAM with separate read/write data
//   buses, per-byte write enables, a registered read with a valid strobe,
//   optional write-readback, and a zero-fill clear sequence after reset.
//   Holds the 128-bit state, round-key and S-box scratch buffers of the
//   AES datapath.
//
// Parameters
//   DATA_WIDTH     word width in bits, multiple of 8
//   ADDR_WIDTH     address width
//   RAM_DEPTH      number of words, at most 2**ADDR_WIDTH
//   WRITE_READBACK 1 = a write with oe high also returns the merged word
//   CLEAR_ON_RESET 1 = zero-fill the whole array after reset
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   address    word address
//   data_in    write data
//   be         byte write enables, be[i] covers data_in[8i+7:8i]
//   cs         chip select
//   we         1 = write, 0 = read
//   oe         read enable / readback enable
//   data_out   registered read data
//   rd_valid   data_out updated this cycle
//   busy       clear in progress, all accesses ignored
//
// Optional feature (macro RAM_PARITY_EN)
//   Stores one even-parity bit per byte and adds:
//   parity_err output, registered with data_out, valid with rd_valid
//   par_inject input, inverts the stored parity bit of byte 0 on a write
// ---------------------------------------------------------------------------
module ram_sp_sr_sw_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int WRITE_READBACK = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    cs,
    input  logic                    we,
    input  logic                    oe,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
`ifdef RAM_PARITY_EN
    output logic                    parity_err,
    input  logic                    par_inject,
`endif
    output logic                    busy
);

    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e                  RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic                    RST_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    // One extra bit so a full 2**ADDR_WIDTH depth is representable.
    localparam logic [ADDR_WIDTH:0]     DEPTH_V   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    // Expand byte enables into a bit mask over the word.
    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [NBYTES-1:0] b);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < NBYTES; i++) begin
            m[8*i +: 8] = {8{b[i]}};
        end
        return m;
    endfunction

`ifdef RAM_PARITY_EN
    // Even parity per byte: the stored bit makes each 9-bit group even.
    function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_WIDTH-1:0] w);
        logic [NBYTES-1:0] p;
        p = '0;
        for (int i = 0; i < NBYTES; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction
`endif

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_e                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    busy_q,     busy_d;

    logic                    addr_ok_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [DATA_WIDTH-1:0]   mask_s;
    logic [DATA_WIDTH-1:0]   merged_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

`ifdef RAM_PARITY_EN
    logic [NBYTES-1:0]       par_mem [RAM_DEPTH];
    logic [NBYTES-1:0]       old_par_s;
    logic [NBYTES-1:0]       new_par_s;
    logic [NBYTES-1:0]       mem_wpar_s;
    logic                    par_err_q, par_err_d;
`endif

    // Address decode, current word lookup and byte-merge of the write data.
    always_comb begin
        addr_ok_s = ({1'b0, address} < DEPTH_V);
        if (addr_ok_s) begin
            rd_word_s = mem[address];
        end else begin
            rd_word_s = '0;
        end
        mask_s   = byte_mask(be);
        merged_s = (rd_word_s & ~mask_s) | (data_in & mask_s);
`ifdef RAM_PARITY_EN
        if (addr_ok_s) begin
            old_par_s = par_mem[address];
        end else begin
            old_par_s = '0;
        end
        // Only enabled bytes get fresh parity; injection flips byte 0's bit.
        new_par_s = ((old_par_s & ~be) | (byte_parity(data_in) & be))
                    ^ {{(NBYTES-1){1'b0}}, par_inject};
`endif
    end

    // Next-state, clear sequencing, array write request and output data.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = address;
        mem_wdata_s = merged_s;
`ifdef RAM_PARITY_EN
        par_err_d   = par_err_q;
        mem_wpar_s  = new_par_s;
`endif
        if (rst) begin
            // Registers are reset in the flop process; block any array write.
            mem_we_s = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = cnt_q;
                    mem_wdata_s = '0;
`ifdef RAM_PARITY_EN
                    mem_wpar_s  = '0;
`endif
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (cs && we) begin
                        // Out-of-range writes are dropped.
                        mem_we_s = addr_ok_s;
                        if ((WRITE_READBACK != 0) && oe) begin
                            // Write-first: return the word as it will be stored.
                            if (addr_ok_s) begin
                                data_out_d = merged_s;
                            end else begin
                                data_out_d = '0;
                            end
                            rd_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
                            if (addr_ok_s) begin
                                par_err_d = |(new_par_s ^ byte_parity(merged_s));
                            end else begin
                                par_err_d = 1'b0;
                            end
`endif
                        end else begin
                            data_out_d = data_out_q;
                        end
                    end else if (cs && oe) begin
                        data_out_d = rd_word_s;
                        rd_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
                        par_err_d  = |(old_par_s ^ byte_parity(rd_word_s));
`endif
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= RST_BUSY;
`ifdef RAM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
`ifdef RAM_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Storage array; no reset so it maps onto RAM resources.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
`ifdef RAM_PARITY_EN
            par_mem[mem_addr_s] <= mem_wpar_s;
`endif
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
`ifdef RAM_PARITY_EN
    assign parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_ram_sp_sr_sw_be.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_sr_sw_be
//   Directed bench for ram_sp_sr_sw_be. Two instances share one stimulus:
//   dut_a uses the defaults (depth 256, no readback), dut_b has depth 200
//   and write-readback enabled, so range and readback behaviour can be
//   checked against the default behaviour on the same cycles.
// ---------------------------------------------------------------------------
module tb_ram_sp_sr_sw_be;

    logic        clk;
    logic        rst;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [3:0]  be;
    logic        cs;
    logic        we;
    logic        oe;
    logic [31:0] data_out_a, data_out_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;
`ifdef RAM_PARITY_EN
    logic        perr_a, perr_b;
    logic        par_inject;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int na, nb;
    bit bad_seen;

    ram_sp_sr_sw_be u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .be         (be),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .data_out   (data_out_a),
        .rd_valid   (rd_valid_a),
`ifdef RAM_PARITY_EN
        .parity_err (perr_a),
        .par_inject (par_inject),
`endif
        .busy       (busy_a)
    );

    ram_sp_sr_sw_be #(
        .RAM_DEPTH      (200),
        .WRITE_READBACK (1)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .be         (be),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .data_out   (data_out_b),
        .rd_valid   (rd_valid_b),
`ifdef RAM_PARITY_EN
        .parity_err (perr_b),
        .par_inject (par_inject),
`endif
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic o,
                         input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = c; we = w; oe = o; address = a; data_in = d; be = b;
    endtask

    // Counts cycles until each busy falls; optionally fires one write at
    // cycle inj. bad_seen flags any rd_valid or non-zero data_out meanwhile.
    task automatic wait_clear(input int inj, output int ca, output int cb, output bit bad);
        ca = -1; cb = -1; bad = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            if (i == inj) drive(1'b1, 1'b1, 1'b1, 8'd3, 32'hFFFF_FFFF, 4'hF);
            else          drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
            tick();
            if (ca < 0 && busy_a === 1'b0) ca = i;
            if (cb < 0 && busy_b === 1'b0) cb = i;
            if (ca < 0 && (rd_valid_a !== 1'b0 || data_out_a !== 32'h0)) bad = 1'b1;
            if (cb < 0 && (rd_valid_b !== 1'b0 || data_out_b !== 32'h0)) bad = 1'b1;
            if (ca >= 0 && cb >= 0) break;
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
`ifdef RAM_PARITY_EN
        par_inject = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy_a",     {31'd0, busy_a},     32'd1);
        chk("rst_busy_b",     {31'd0, busy_b},     32'd1);
        chk("rst_data_a",     data_out_a,          32'h0);
        chk("rst_rdvalid_a",  {31'd0, rd_valid_a}, 32'd0);
        chk("rst_data_b",     data_out_b,          32'h0);
`ifdef RAM_PARITY_EN
        chk("rst_perr_a",     {31'd0, perr_a},     32'd0);
`endif

        // Clear length after reset release
        rst = 1'b0;
        wait_clear(0, na, nb, bad_seen);
        chk("clear_len_a", na, 32'd256);
        chk("clear_len_b", nb, 32'd200);
        chk("clear_quiet", {31'd0, bad_seen}, 32'd0);

        // Read of last word after clear (out of range for dut_b)
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 32'h0, 4'h0); tick();
        chk("rd_ff_data_a", data_out_a, 32'h0);
        chk("rd_ff_vld_a",  {31'd0, rd_valid_a}, 32'd1);
        chk("rd_ff_vld_b",  {31'd0, rd_valid_b}, 32'd1);

        // Byte enables
        drive(1'b1, 1'b1, 1'b0, 8'd5, 32'hAABB_CCDD, 4'b1111); tick();
        chk("wr_novld_a", {31'd0, rd_valid_a}, 32'd0);
        chk("wr_novld_b", {31'd0, rd_valid_b}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd5, 32'h1122_3344, 4'b0101); tick();
        drive(1'b1, 1'b1, 1'b0, 8'd5, 32'hFFFF_FFFF, 4'b0000); tick();
        drive(1'b1, 1'b0, 1'b1, 8'd5, 32'h0, 4'h0); tick();
        chk("be_merge_a", data_out_a, 32'hAA22_CC44);
        chk("be_merge_b", data_out_b, 32'hAA22_CC44);

        // Read pipeline
        drive(1'b1, 1'b1, 1'b0, 8'd1, 32'h1, 4'hF); tick();
        drive(1'b1, 1'b1, 1'b0, 8'd2, 32'h2, 4'hF); tick();
        drive(1'b1, 1'b1, 1'b0, 8'd3, 32'h3, 4'hF); tick();
        drive(1'b1, 1'b0, 1'b1, 8'd1, 32'h0, 4'h0); tick();
        chk("pipe1_data", data_out_a, 32'h1);
        chk("pipe1_vld",  {31'd0, rd_valid_a}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'd2, 32'h0, 4'h0); tick();
        chk("pipe2_data", data_out_a, 32'h2);
        chk("pipe2_vld",  {31'd0, rd_valid_a}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'd3, 32'h0, 4'h0); tick();
        chk("pipe3_data", data_out_a, 32'h3);
        chk("pipe3_vld",  {31'd0, rd_valid_a}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'd1, 32'h0, 4'h0); tick();
        chk("oe0_hold_a", data_out_a, 32'h3);
        chk("oe0_vld_a",  {31'd0, rd_valid_a}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd1, 32'h0, 4'h0); tick();
        chk("cs0_hold_b", data_out_b, 32'h3);
        chk("cs0_vld_b",  {31'd0, rd_valid_b}, 32'd0);

        // Write readback (dut_b) vs plain write (dut_a)
        drive(1'b1, 1'b1, 1'b1, 8'd7, 32'hDEAD_BEEF, 4'hF); tick();
        chk("rb_data_b", data_out_b, 32'hDEAD_BEEF);
        chk("rb_vld_b",  {31'd0, rd_valid_b}, 32'd1);
        chk("norb_hold_a", data_out_a, 32'h3);
        chk("norb_vld_a",  {31'd0, rd_valid_a}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 8'd5, 32'h0000_0099, 4'b0001); tick();
        chk("rb_merge_b", data_out_b, 32'hAA22_CC99);
        drive(1'b1, 1'b0, 1'b1, 8'd7, 32'h0, 4'h0); tick();
        chk("rd7_a", data_out_a, 32'hDEAD_BEEF);

        // Address range: 250 is valid for dut_a only
        drive(1'b1, 1'b1, 1'b0, 8'd250, 32'h1234_5678, 4'hF); tick();
        drive(1'b1, 1'b0, 1'b1, 8'd250, 32'h0, 4'h0); tick();
        chk("rng_data_a", data_out_a, 32'h1234_5678);
        chk("rng_data_b", data_out_b, 32'h0);
        chk("rng_vld_b",  {31'd0, rd_valid_b}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'd5, 32'h0, 4'h0); tick();
        chk("rd5_a", data_out_a, 32'hAA22_CC99);

`ifdef RAM_PARITY_EN
        // Parity injection and repair
        par_inject = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'd9, 32'h0000_00FF, 4'hF); tick();
        par_inject = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 8'd9, 32'h0, 4'h0); tick();
        chk("perr_inj_a", {31'd0, perr_a}, 32'd1);
        chk("perr_inj_b", {31'd0, perr_b}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 8'd9, 32'h0000_00FF, 4'hF); tick();
        drive(1'b1, 1'b0, 1'b1, 8'd9, 32'h0, 4'h0); tick();
        chk("perr_ok_a", {31'd0, perr_a}, 32'd0);
        chk("perr_ok_data_a", data_out_a, 32'h0000_00FF);
`endif

        // Mid-clear reset, with a write attempted while busy
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        rst = 1'b1; tick();
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1; tick();
        chk("mid_busy_a", {31'd0, busy_a}, 32'd1);
        chk("mid_busy_b", {31'd0, busy_b}, 32'd1);
        chk("mid_data_a", data_out_a, 32'h0);
        rst = 1'b0;
        wait_clear(50, na, nb, bad_seen);
        chk("reclear_len_a", na, 32'd256);
        chk("reclear_len_b", nb, 32'd200);
        chk("busy_ignored", {31'd0, bad_seen}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 8'd3, 32'h0, 4'h0); tick();
        chk("busy_wr_a", data_out_a, 32'h0);
        chk("busy_wr_b", data_out_b, 32'h0);
        chk("busy_wr_vld", {31'd0, rd_valid_a}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'd5, 32'h0, 4'h0); tick();
        chk("cleared5_a", data_out_a, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 8'd250, 32'h0, 4'h0); tick();
        chk("cleared250_a", data_out_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_sr_sw_be.md
Name: ram_sp_sr_sw_be

Overview:
Parametrised single-port synchronous RAM. Successor to the byte-wide single-port RAM used for AES state and key storage.
- Adds separate in/out data buses, per-byte write enables, a registered read with valid strobe, and optional write-readback.
- Adds a reset-triggered clear state machine that zero-fills the array one word per cycle.
- Used for the 128-bit state, round-key and S-box scratch buffers in the AES datapath.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (NBYTES = DATA_WIDTH/8).
ADDR_WIDTH, 8, address width.
RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be at most 2^ADDR_WIDTH.
WRITE_READBACK, 0, 1 = a write with oe high also returns the merged new word on data_out.
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset, synchronous, active-high.
address  input  ADDR_WIDTH  word address.
data_in  input  DATA_WIDTH  write data.
be  input  NBYTES  byte write enables; bit i covers data_in[8i+7:8i].
cs  input  1  chip select.
we  input  1  1 = write, 0 = read.
oe  input  1  read enable (and readback enable when WRITE_READBACK=1).
data_out  output  DATA_WIDTH  registered read data.
rd_valid  output  1  data_out updated this cycle.
busy  output  1  clear in progress; all accesses ignored.

Behaviour:
- Reset: rst high at a clock edge sets data_out=0, rd_valid=0 and clear counter=0.
  - CLEAR_ON_RESET=1: state=CLEAR, busy=1.
  - CLEAR_ON_RESET=0: state=IDLE, busy=0; array contents left undefined.
- States are CLEAR and IDLE.
- CLEAR state:
  - Each cycle with rst low, mem[cnt] <= 0 and cnt increments.
  - After the write to word RAM_DEPTH-1, go to IDLE; busy falls on that edge.
  - Clear takes exactly RAM_DEPTH cycles after rst deasserts.
  - rst reasserted mid-clear restarts cnt at 0.
- While busy: cs/we/oe are ignored, no array writes, rd_valid=0, data_out holds its value.
- Write (IDLE, cs=1, we=1):
  - For each i with be[i]=1, byte i of mem[address] <= byte i of data_in; other bytes unchanged.
  - be all zero leaves the word unchanged.
- Write readback: if WRITE_READBACK=1 and oe=1 during a write, data_out <= merged post-write word and rd_valid=1 next cycle (write-first).
  - Otherwise a write leaves data_out unchanged and rd_valid=0.
- Read (IDLE, cs=1, we=0, oe=1): data_out <= mem[address] at the edge; rd_valid=1 for that one cycle (1-cycle latency).
- Any other input combination: rd_valid=0, data_out holds.
- Back-to-back reads give one result per cycle; there are no stall cycles in IDLE.
- Out-of-range address (address >= RAM_DEPTH): write ignored; read returns all-zero with rd_valid=1.
- No tristate; data_out is never X after reset.

Optional Feature:
RAM_PARITY_EN
- With the macro:
  - One even-parity bit is stored per byte.
  - Output parity_err (1 bit) is registered alongside data_out and is valid when rd_valid=1; it is 1 if any byte's stored parity mismatches the recomputed parity.
  - Input par_inject (1 bit): when high during a write, the stored parity bit of byte 0 is inverted.
  - Clear writes parity 0.
  - Partial writes update parity only for enabled bytes.
  - parity_err resets to 0.
- Without the macro: no parity storage, and ports parity_err and par_inject do not exist.

Test Plan:
1. Reset clear: rst=1 for 2 cycles, then 0 with DEPTH=256 -> busy=1 for exactly 256 cycles after rst falls, then 0; a read of addr 0xFF then returns 0x00000000 with rd_valid=1 one cycle later.
2. Byte enables: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read of addr 5 gives 0xAA22CC44.
3. Read pipeline: consecutive reads of addrs 1, 2, 3 preloaded 0x1, 0x2, 0x3 -> rd_valid high 3 cycles, data_out = 0x1, 0x2, 0x3 each lagging by 1 cycle; with oe=0 -> rd_valid=0 and data_out holds.
4. Mid-clear reset: rst pulsed at clear cycle 100 -> busy stays 1, clear restarts, and busy falls 256 cycles after the second rst deassertion; writes issued while busy have no effect.
5. Readback and range: with WRITE_READBACK=1, write 0xDEADBEEF with oe=1 -> data_out=0xDEADBEEF, rd_valid=1 next cycle; with DEPTH=200, a write to addr 250 is ignored and a read of addr 250 gives 0.
6. RAM_PARITY_EN: write 0x000000FF with par_inject=1 -> read gives parity_err=1; rewrite with par_inject=0 -> parity_err=0.
